// File: rtl/tsxb_ps_loader.sv
// rtl/tsxb_ps_loader.sv - buffered passive-serial FPGA configuration loader on ZX-BUS
module tsxb_ps_loader #(
  parameter logic [7:0] PORT_LO = 8'hAF,
  parameter logic [7:0] CTRL_HI = 8'hF0,
  parameter int         FIFO_AW = 4,
  parameter int         CLK_DIV = 1
) (
  input  logic        CLK50,
  input  logic        RST,
  input  logic [15:0] ZA,
  input  logic [7:0]  ZD_I,
  output logic [7:0]  ZD_O,
  output logic        ZD_OE,
  input  logic        ZRD_N,
  input  logic        ZWR_N,
  input  logic        ZIORQ_N,
  input  logic        NSTATUS,
  input  logic        CONF_DONE,
  input  logic        NCONFIG_I,
  output logic        NCONFIG_DRV,
  output logic        MSEL0_DRV,
  output logic        DCLK,
  output logic        DATA0,
  output logic        PS_OE
);

  localparam int         DEPTH    = 1 << FIFO_AW;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_LO = 2'b01, S_HI = 2'b10} state_t;

  logic hit, ctrl_sel, data_sel;
  logic [2:0] cw_sync, dw_sync, ncfg_sync, nst_sync;
  logic [1:0] cd_sync;
  logic cw_pulse, dw_pulse;
  logic nst_s, cd_s, nst_fall, ncfg_rise;
  logic nconfig_r, msel0_r, ps_lat, ps_mode;
  logic ovf, err;
  logic flush_req, clr_req, nst_abort, fifo_flush, abort, busy;
  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count;
  logic full, empty, push, pop;
  logic [7:0] fifo_head;
  state_t state, state_n;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic div_done, dclk_c;

  assign hit      = !ZIORQ_N && (ZA[7:0] == PORT_LO);
  assign ctrl_sel = hit && (ZA[15:8] == CTRL_HI);
  assign data_sel = hit && ZA[15] && (ZA[15:8] != CTRL_HI);
  assign ZD_OE    = ctrl_sel && !ZRD_N;

  // Strobes and FPGA status pins are asynchronous; every action keys off a registered edge pulse.
  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      cw_sync   <= '0;
      dw_sync   <= '0;
      ncfg_sync <= '0;
      nst_sync  <= '0;
      cd_sync   <= '0;
      cw_pulse  <= 1'b0;
      dw_pulse  <= 1'b0;
    end else begin
      cw_sync   <= {cw_sync[1:0], ctrl_sel && !ZWR_N};
      dw_sync   <= {dw_sync[1:0], data_sel && !ZWR_N};
      ncfg_sync <= {ncfg_sync[1:0], NCONFIG_I};
      nst_sync  <= {nst_sync[1:0], NSTATUS};
      cd_sync   <= {cd_sync[0], CONF_DONE};
      cw_pulse  <= cw_sync[1] && !cw_sync[2];
      dw_pulse  <= dw_sync[1] && !dw_sync[2];
    end
  end

  assign nst_s     = nst_sync[1];
  assign nst_fall  = nst_sync[2] && !nst_sync[1];
  assign cd_s      = cd_sync[1];
  assign ncfg_rise = ncfg_sync[1] && !ncfg_sync[2];

  assign flush_req  = cw_pulse && ZD_I[2];
  assign clr_req    = cw_pulse && ZD_I[3];
  assign busy       = (state != S_IDLE);
  assign nst_abort  = nst_fall && busy;
  assign fifo_flush = flush_req || nst_abort;
  assign abort      = busy && (!ps_mode || flush_req || nst_fall);
  assign ps_mode    = ps_lat && !cd_s;

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      nconfig_r <= 1'b0;
      msel0_r   <= 1'b0;
      ps_lat    <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (cw_pulse) begin
        nconfig_r <= ZD_I[0];
        msel0_r   <= ZD_I[1];
      end
      if (ncfg_rise) ps_lat <= msel0_r;
      if (clr_req) begin
        ovf <= 1'b0;
        err <= 1'b0;
      end
      if (dw_pulse && ps_mode && full) ovf <= 1'b1;
      if (nst_abort) err <= 1'b1;
    end
  end

  // count[FIFO_AW] is set only when all DEPTH slots are occupied
  assign full      = count[FIFO_AW];
  assign empty     = (count == '0);
  assign push      = dw_pulse && ps_mode && !full && !fifo_flush;
  assign fifo_head = mem[rd_ptr];

  always_ff @(posedge CLK50) begin
    if (push) mem[wr_ptr] <= ZD_I;
  end

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (fifo_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign div_done = (div_cnt == DIV_LAST);

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: if (ps_mode && !empty && !fifo_flush) begin
        pop     = 1'b1;
        state_n = S_LO;
      end
      S_LO: begin
        if (abort)         state_n = S_IDLE;
        else if (div_done) state_n = S_HI;
      end
      S_HI: begin
        if (abort) state_n = S_IDLE;
        else if (div_done) begin
          if (bit_cnt != 3'd7) state_n = S_LO;
          else if (!empty) begin
            pop     = 1'b1;
            state_n = S_LO;
          end else state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    dclk_c = (state == S_HI);
  end

  // sh only changes on LO entry, so DATA0 = sh[0] moves exactly on the DCLK falling edge.
  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sh      <= '0;
    end else begin
      if (state == S_IDLE || state_n != state) div_cnt <= '0;
      else                                     div_cnt <= div_cnt + 8'd1;
      if (pop) begin
        sh      <= fifo_head;
        bit_cnt <= '0;
      end else if (state == S_HI && state_n == S_LO) begin
        sh      <= {1'b0, sh[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign ZD_O        = {cd_s, full, empty, err, ovf, 1'b0, ps_mode, nst_s};
  assign DCLK        = dclk_c;
  assign DATA0       = sh[0];
  assign PS_OE       = ps_mode;
  assign NCONFIG_DRV = nconfig_r;
  assign MSEL0_DRV   = msel0_r;

endmodule

// File: tb/tb_tsxb_ps_loader.sv
// tb/tb_tsxb_ps_loader.sv - directed self-checking bench for tsxb_ps_loader
module tb_tsxb_ps_loader;

  logic CLK50 = 1'b0;
  logic RST;
  logic [15:0] ZA;
  logic [7:0] ZD_I;
  logic ZRD_N, ZWR_N, ZIORQ_N, NSTATUS, CONF_DONE;

  logic [7:0] f_zd_o, s_zd_o;
  logic f_zd_oe, f_ncfg_drv, f_msel, f_dclk, f_data0, f_ps_oe;
  logic s_zd_oe, s_ncfg_drv, s_msel, s_dclk, s_data0, s_ps_oe;
  logic f_ncfg_i, s_ncfg_i;

  // nCONFIG has a pull-up on the board: the sensed level is the inverse of the pull-down drive
  assign f_ncfg_i = !f_ncfg_drv;
  assign s_ncfg_i = !s_ncfg_drv;

  always #5 CLK50 = !CLK50;

  tsxb_ps_loader #(.FIFO_AW(2), .CLK_DIV(1)) u_fast (
    .CLK50(CLK50), .RST(RST), .ZA(ZA), .ZD_I(ZD_I), .ZD_O(f_zd_o), .ZD_OE(f_zd_oe),
    .ZRD_N(ZRD_N), .ZWR_N(ZWR_N), .ZIORQ_N(ZIORQ_N), .NSTATUS(NSTATUS), .CONF_DONE(CONF_DONE),
    .NCONFIG_I(f_ncfg_i), .NCONFIG_DRV(f_ncfg_drv), .MSEL0_DRV(f_msel), .DCLK(f_dclk),
    .DATA0(f_data0), .PS_OE(f_ps_oe));

  tsxb_ps_loader #(.FIFO_AW(2), .CLK_DIV(64)) u_slow (
    .CLK50(CLK50), .RST(RST), .ZA(ZA), .ZD_I(ZD_I), .ZD_O(s_zd_o), .ZD_OE(s_zd_oe),
    .ZRD_N(ZRD_N), .ZWR_N(ZWR_N), .ZIORQ_N(ZIORQ_N), .NSTATUS(NSTATUS), .CONF_DONE(CONF_DONE),
    .NCONFIG_I(s_ncfg_i), .NCONFIG_DRV(s_ncfg_drv), .MSEL0_DRV(s_msel), .DCLK(s_dclk),
    .DATA0(s_data0), .PS_OE(s_ps_oe));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int f_bits[$], f_rise[$], s_bits[$], s_rise[$];
  logic f_prev = 1'b0, s_prev = 1'b0;

  always @(posedge CLK50) cyc <= cyc + 1;

  // DATA0 is logged at every DCLK rise, with the cycle number of that rise
  always @(negedge CLK50) begin
    f_prev <= f_dclk;
    s_prev <= s_dclk;
    if (f_dclk && !f_prev) begin
      f_bits.push_back(int'(f_data0));
      f_rise.push_back(cyc);
    end
    if (s_dclk && !s_prev) begin
      s_bits.push_back(int'(s_data0));
      s_rise.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK50);
    #1;
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
    ZA = a; ZD_I = d; ZIORQ_N = 1'b0; ZWR_N = 1'b0;
    step(6);
    ZIORQ_N = 1'b1; ZWR_N = 1'b1;
    step(2);
  endtask

  task automatic rd_status(output logic [7:0] fs, output logic [7:0] ss, output logic oe);
    ZA = 16'hF0AF; ZIORQ_N = 1'b0; ZRD_N = 1'b0;
    #1;
    fs = f_zd_o; ss = s_zd_o; oe = f_zd_oe;
    ZRD_N = 1'b1; ZIORQ_N = 1'b1;
    #1;
  endtask

  task automatic clear_logs();
    f_bits.delete(); f_rise.delete(); s_bits.delete(); s_rise.delete();
  endtask

  function automatic int pack_bits(input int q[$]);
    int w = 0;
    for (int i = 0; i < q.size() && i < 32; i++) w = w | ((q[i] & 1) << i);
    return w;
  endfunction

  function automatic int bad_gaps(input int q[$], input int per);
    int b = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] != per) b++;
    return b;
  endfunction

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    logic [7:0] fs, ss;
    logic oe;
    int t0, n;
    RST = 1'b1; ZA = '0; ZD_I = '0; ZRD_N = 1'b1; ZWR_N = 1'b1; ZIORQ_N = 1'b1;
    NSTATUS = 1'b1; CONF_DONE = 1'b0;
    step(3);
    RST = 1'b0;
    step(4);

    rd_status(fs, ss, oe);
    chk("rst_status_fast", fs, 8'h21);
    chk("rst_status_slow", ss, 8'h21);
    chk("rst_zd_oe_read", oe, 1);
    chk("rst_zd_oe_idle", f_zd_oe, 0);
    chk("rst_drives_fast", {f_ncfg_drv, f_msel, f_dclk, f_data0, f_ps_oe}, 0);
    chk("rst_drives_slow", {s_ncfg_drv, s_msel, s_dclk, s_data0, s_ps_oe}, 0);
    ZA = 16'h80AF; ZIORQ_N = 1'b0; ZRD_N = 1'b0;
    #1;
    chk("data_port_no_oe", f_zd_oe, 0);
    ZRD_N = 1'b1; ZIORQ_N = 1'b1;
    step(1);

    io_wr(16'hF0AF, 8'h03);
    chk("ncfg_drv_on", f_ncfg_drv, 1);
    chk("msel_on", f_msel, 1);
    chk("ps_oe_before_release", f_ps_oe, 0);
    io_wr(16'hF0AF, 8'h02);
    step(4);
    chk("ncfg_drv_off", f_ncfg_drv, 0);
    chk("ps_oe_mode", f_ps_oe, 1);
    rd_status(fs, ss, oe);
    chk("mode_status_fast", fs, 8'h23);
    chk("mode_status_slow", ss, 8'h23);

    // single byte A5: strobe start to first DCLK rise is 5 + CLK_DIV cycles
    clear_logs();
    t0 = cyc;
    io_wr(16'h80AF, 8'hA5);
    for (int i = 0; i < 100 && f_bits.size() < 8; i++) step(1);
    step(6);
    chk("a5_rise_count", f_bits.size(), 8);
    chk("a5_bits", pack_bits(f_bits), 32'hA5);
    chk("a5_latency_fast", first_of(f_rise) - t0, 6);
    chk("a5_period", bad_gaps(f_rise, 2), 0);
    chk("a5_idle_dclk", f_dclk, 0);
    rd_status(fs, ss, oe);
    chk("a5_status_fast", fs, 8'h23);
    for (int i = 0; i < 200 && s_rise.size() < 1; i++) step(1);
    chk("a5_latency_slow", first_of(s_rise) - t0, 69);
    chk("a5_slow_dclk_high", s_dclk, 1);

    io_wr(16'hF0AF, 8'h06);
    chk("flush_abort_dclk", s_dclk, 0);
    step(150);
    chk("flush_no_more_rises", s_bits.size(), 1);

    // three-byte burst must come out as 24 contiguous DCLK pulses
    clear_logs();
    io_wr(16'h80AF, 8'h01);
    io_wr(16'h80AF, 8'h80);
    io_wr(16'h80AF, 8'hFF);
    for (int i = 0; i < 200 && f_bits.size() < 24; i++) step(1);
    step(20);
    chk("burst_rise_count", f_bits.size(), 24);
    chk("burst_bits", pack_bits(f_bits), 32'h00FF8001);
    chk("burst_contiguous", bad_gaps(f_rise, 2), 0);
    chk("burst_idle_dclk", f_dclk, 0);
    io_wr(16'hF0AF, 8'h06);
    step(2);

    // slow instance: first byte sits in the shifter, FIFO holds four more
    io_wr(16'h80AF, 8'h11);
    io_wr(16'h80AF, 8'h12);
    io_wr(16'h80AF, 8'h13);
    io_wr(16'h80AF, 8'h14);
    rd_status(fs, ss, oe);
    chk("fill4_status", ss, 8'h03);
    io_wr(16'h80AF, 8'h15);
    rd_status(fs, ss, oe);
    chk("fill5_full", ss, 8'h43);
    io_wr(16'h80AF, 8'h16);
    rd_status(fs, ss, oe);
    chk("fill6_ovf", ss, 8'h4B);
    io_wr(16'hF0AF, 8'h08);
    rd_status(fs, ss, oe);
    chk("ovf_cleared", ss, 8'h43);
    chk("msel_cleared", s_msel, 0);
    io_wr(16'hF0AF, 8'h06);
    rd_status(fs, ss, oe);
    chk("fill_flushed", ss, 8'h23);
    step(4);

    // nSTATUS drops with the second byte mid-shift and a third byte queued
    clear_logs();
    io_wr(16'h80AF, 8'hC3);
    io_wr(16'h80AF, 8'h3C);
    io_wr(16'h80AF, 8'h55);
    for (int i = 0; i < 100 && f_bits.size() < 10; i++) step(1);
    NSTATUS = 1'b0;
    step(4);
    chk("nst_dclk_low", f_dclk, 0);
    n = f_bits.size();
    step(30);
    chk("nst_no_more_rises", f_bits.size(), n);
    chk("nst_partial_byte", (n > 8 && n < 16), 1);
    rd_status(fs, ss, oe);
    chk("nst_status_fast", fs, 8'h32);
    chk("nst_status_slow", ss, 8'h32);
    NSTATUS = 1'b1;
    step(4);
    io_wr(16'hF0AF, 8'h0A);
    rd_status(fs, ss, oe);
    chk("err_cleared", fs, 8'h23);
    step(1);

    // CONF_DONE ends PS mode mid-byte; later data writes are ignored
    clear_logs();
    io_wr(16'h80AF, 8'h96);
    for (int i = 0; i < 100 && f_bits.size() < 3; i++) step(1);
    CONF_DONE = 1'b1;
    step(5);
    chk("cd_ps_oe", f_ps_oe, 0);
    chk("cd_dclk", f_dclk, 0);
    n = f_bits.size();
    step(30);
    chk("cd_no_more_rises", f_bits.size(), n);
    rd_status(fs, ss, oe);
    chk("cd_status", fs, 8'hA1);
    io_wr(16'h80AF, 8'h5A);
    step(20);
    rd_status(fs, ss, oe);
    chk("cd_write_ignored", fs, 8'hA1);
    chk("cd_write_no_rises", f_bits.size(), n);

    // reset asserted while DCLK is high must drop it at once
    CONF_DONE = 1'b0;
    step(4);
    io_wr(16'h80AF, 8'hFF);
    for (int i = 0; i < 40 && !f_dclk; i++) step(1);
    chk("pre_reset_dclk_high", f_dclk, 1);
    RST = 1'b1;
    #1;
    chk("reset_dclk_low", f_dclk, 0);
    chk("reset_ps_oe", f_ps_oe, 0);
    step(2);
    RST = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
